rob_writeback_commit: RTL and testbench

Consumer end of the M/WB pipeline register: takes results leaving the M_WB stage, marks the matching reorder-buffer entry complete, and retires entries strictly in program order through a commit port. It owns the ROB allocation pointer handed to decode, so it is the single point where out-of-order completion becomes in-order architectural retirement. An exception on the oldest entry flushes the whole buffer.

---
 rtl/rob_writeback_commit_if.sv | 59 +++++
 rtl/rob_writeback_commit.sv | 134 +++++++++++++
 tb/tb_rob_writeback_commit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_writeback_commit_if.sv
// M/WB writeback and ROB commit bundle.
// Holds allocation, completion and commit signals of rob_writeback_commit.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface rob_writeback_commit_if #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int ROB_ENTRIES = 8
);
  localparam int CW = $clog2(ROB_ENTRIES) + 1;

  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [6:0]           alloc_rob_id;

  logic                 valid;
  logic [6:0]           rob_id;
  logic [1:0]           instruction_type;
  logic [WORD_SIZE-1:0] pc;
  logic                 exception;
  logic [WORD_SIZE-1:0] virtual_addr_exception;
  logic [WORD_SIZE-1:0] aluResult;

  logic                 commit_valid;
  logic [6:0]           commit_rob_id;
  logic [1:0]           commit_instruction_type;
  logic [WORD_SIZE-1:0] commit_pc;
  logic                 commit_exception;
  logic [WORD_SIZE-1:0] commit_virtual_addr_exception;
  logic [WORD_SIZE-1:0] commit_aluResult;

  logic                 flush;
  logic [CW-1:0]        rob_count;

  modport master (
    output alloc_valid, valid, rob_id,
    output instruction_type, pc, exception,
    output virtual_addr_exception, aluResult,
    input  alloc_ready, alloc_rob_id,
    input  commit_valid, commit_rob_id,
    input  commit_instruction_type, commit_pc,
    input  commit_exception,
    input  commit_virtual_addr_exception,
    input  commit_aluResult, flush, rob_count
  );

  modport slave (
    input  alloc_valid, valid, rob_id,
    input  instruction_type, pc, exception,
    input  virtual_addr_exception, aluResult,
    output alloc_ready, alloc_rob_id,
    output commit_valid, commit_rob_id,
    output commit_instruction_type, commit_pc,
    output commit_exception,
    output commit_virtual_addr_exception,
    output commit_aluResult, flush, rob_count
  );
endinterface

// File: rtl/rob_writeback_commit.sv
// Reorder buffer: marks M/WB results complete and retires in order.
// Optional ROB_COMMIT_BYPASS_EN lets a head completion commit same cycle.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module rob_writeback_commit #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int ROB_ENTRIES = 8
) (
  input logic clk,
  input logic reset,
  rob_writeback_commit_if.slave wb
);
  localparam int IW = $clog2(ROB_ENTRIES);
  localparam int CW = IW + 1;

  logic [ROB_ENTRIES-1:0] alloc_q;
  logic [ROB_ENTRIES-1:0] cmpl_q;
  logic [ROB_ENTRIES-1:0] exc_q;
  logic [1:0]             type_q [ROB_ENTRIES];
  logic [WORD_SIZE-1:0]   pc_q   [ROB_ENTRIES];
  logic [WORD_SIZE-1:0]   va_q   [ROB_ENTRIES];
  logic [WORD_SIZE-1:0]   res_q  [ROB_ENTRIES];

  logic [IW-1:0] head_q;
  logic [IW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          flush_q;

  logic [IW-1:0] idx;
  logic          full;
  logic          head_done;
  logic          byp;
  logic          cv;
  logic          c_exc;
  logic          exc_fire;
  logic          alloc_fire;
  logic          wr_fire;
  logic          unused_ok;

  assign idx       = wb.rob_id[IW-1:0];
  assign unused_ok = &{1'b0, wb.rob_id};
  assign full      = count_q == CW'(ROB_ENTRIES);
  assign head_done = alloc_q[head_q] && cmpl_q[head_q];

`ifdef ROB_COMMIT_BYPASS_EN
  assign byp = alloc_q[head_q] && !cmpl_q[head_q]
            && wb.valid && (idx == head_q);
`else
  assign byp = 1'b0;
`endif

  assign cv         = head_done || byp;
  assign exc_fire   = cv && c_exc;
  assign wb.alloc_ready = !full && !flush_q && !exc_fire;
  assign alloc_fire = wb.alloc_valid && wb.alloc_ready;
  assign wr_fire    = wb.valid && alloc_q[idx] && !cmpl_q[idx]
                   && !flush_q && !byp;

  always_comb begin
    c_exc                            = 1'b0;
    wb.commit_rob_id                 = '0;
    wb.commit_instruction_type       = '0;
    wb.commit_pc                     = '0;
    wb.commit_virtual_addr_exception = '0;
    wb.commit_aluResult              = '0;
    if (head_done) begin
      c_exc                            = exc_q[head_q];
      wb.commit_rob_id                 = 7'(head_q);
      wb.commit_instruction_type       = type_q[head_q];
      wb.commit_pc                     = pc_q[head_q];
      wb.commit_virtual_addr_exception = va_q[head_q];
      wb.commit_aluResult              = res_q[head_q];
    end else if (byp) begin
      c_exc                            = wb.exception;
      wb.commit_rob_id                 = 7'(head_q);
      wb.commit_instruction_type       = wb.instruction_type;
      wb.commit_pc                     = wb.pc;
      wb.commit_virtual_addr_exception = wb.virtual_addr_exception;
      wb.commit_aluResult              = wb.aluResult;
    end
  end

  assign wb.commit_valid     = cv;
  assign wb.commit_exception = c_exc;
  assign wb.alloc_rob_id     = 7'(tail_q);
  assign wb.flush            = flush_q;
  assign wb.rob_count        = count_q;

  // Exception commit wipes the buffer; it overrides every other update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_q <= '0;
      cmpl_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else if (exc_fire) begin
      alloc_q <= '0;
      cmpl_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      if (wr_fire)
        cmpl_q[idx] <= 1'b1;
      if (alloc_fire) begin
        alloc_q[tail_q] <= 1'b1;
        cmpl_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (cv) begin
        alloc_q[head_q] <= 1'b0;
        cmpl_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(alloc_fire) - CW'(cv);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      exc_q[idx]  <= wb.exception;
      type_q[idx] <= wb.instruction_type;
      pc_q[idx]   <= wb.pc;
      va_q[idx]   <= wb.virtual_addr_exception;
      res_q[idx]  <= wb.aluResult;
    end
  end
endmodule

// File: tb/tb_rob_writeback_commit.sv
// Directed bench for rob_writeback_commit.
// Build with ROB_COMMIT_BYPASS_EN to check the same-cycle commit path.
module tb_rob_writeback_commit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  rob_writeback_commit_if #(.WORD_SIZE(32), .ROB_ENTRIES(8)) bus ();

  rob_writeback_commit #(.WORD_SIZE(32), .ROB_ENTRIES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 0;
    bus.valid = 0;
    bus.rob_id = 0;
    bus.instruction_type = 0;
    bus.pc = 0;
    bus.exception = 0;
    bus.virtual_addr_exception = 0;
    bus.aluResult = 0;
  endtask

  task automatic done(input int id, input logic [31:0] res);
    bus.valid = 1;
    bus.rob_id = 7'(id);
    bus.aluResult = res;
    bus.instruction_type = 2'(id);
    bus.pc = 32'(id * 4);
  endtask

  initial begin
    idle();
    #12;
    settle();
    chk("rst_count", 64'(bus.rob_count), 0);
    chk("rst_cv", 64'(bus.commit_valid), 0);
    chk("rst_ready", 64'(bus.alloc_ready), 1);
    chk("rst_id", 64'(bus.alloc_rob_id), 0);
    chk("rst_flush", 64'(bus.flush), 0);
    chk("rst_res", 64'(bus.commit_aluResult), 0);
    reset = 1;
    tick();

    // allocate 0,1,2
    bus.alloc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("alloc_id", 64'(bus.alloc_rob_id), 64'(i));
      tick();
    end
    bus.alloc_valid = 0;
    settle();
    chk("cnt3", 64'(bus.rob_count), 3);

    done(2, 30);
    settle();
    chk("no_cv_a", 64'(bus.commit_valid), 0);
    tick();
    idle();
    settle();
    chk("no_early_2", 64'(bus.commit_valid), 0);
    done(0, 10);
    settle();
    chk("no_cv_b", 64'(bus.commit_valid), 0);
    tick();
    done(1, 20);
    settle();
    chk("c0_v", 64'(bus.commit_valid), 1);
    chk("c0_id", 64'(bus.commit_rob_id), 0);
    chk("c0_res", 64'(bus.commit_aluResult), 10);
    tick();
    idle();
    settle();
    chk("c1_v", 64'(bus.commit_valid), 1);
    chk("c1_id", 64'(bus.commit_rob_id), 1);
    chk("c1_res", 64'(bus.commit_aluResult), 20);
    tick();
    chk("c2_v", 64'(bus.commit_valid), 1);
    chk("c2_id", 64'(bus.commit_rob_id), 2);
    chk("c2_res", 64'(bus.commit_aluResult), 30);
    chk("c2_type", 64'(bus.commit_instruction_type), 2);
    chk("c2_pc", 64'(bus.commit_pc), 8);
    chk("c2_cnt", 64'(bus.rob_count), 1);
    tick();
    chk("empty_cv", 64'(bus.commit_valid), 0);
    chk("empty_cnt", 64'(bus.rob_count), 0);

    // three live entries, then async reset mid-cycle
    bus.alloc_valid = 1;
    tick(); tick(); tick();
    bus.alloc_valid = 0;
    settle();
    chk("pre_rst_cnt", 64'(bus.rob_count), 3);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_cnt", 64'(bus.rob_count), 0);
    chk("mid_rst_cv", 64'(bus.commit_valid), 0);
    chk("mid_rst_id", 64'(bus.alloc_rob_id), 0);
    tick();
    reset = 1;
    tick();
    chk("post_rst_rdy", 64'(bus.alloc_ready), 1);

    // spurious completion to unallocated 5
    bus.alloc_valid = 1;
    tick();
    bus.alloc_valid = 0;
    done(5, 99);
    settle();
    chk("spur_cv_a", 64'(bus.commit_valid), 0);
    tick();
    idle();
    settle();
    chk("spur_cv_b", 64'(bus.commit_valid), 0);
    chk("spur_cnt", 64'(bus.rob_count), 1);

    // fill to 8, then wrap
    bus.alloc_valid = 1;
    for (int i = 1; i < 8; i++) begin
      settle();
      chk("fill_id", 64'(bus.alloc_rob_id), 64'(i));
      tick();
    end
    bus.alloc_valid = 0;
    settle();
    chk("full_cnt", 64'(bus.rob_count), 8);
    chk("full_rdy", 64'(bus.alloc_ready), 0);
    done(0, 5);
    tick();
    idle();
    bus.alloc_valid = 1;
    settle();
    chk("full_cv", 64'(bus.commit_valid), 1);
    chk("full_rdy2", 64'(bus.alloc_ready), 0);
    tick();
    chk("wrap_cnt7", 64'(bus.rob_count), 7);
    chk("wrap_rdy", 64'(bus.alloc_ready), 1);
    chk("wrap_id", 64'(bus.alloc_rob_id), 0);
    tick();
    bus.alloc_valid = 0;
    settle();
    chk("wrap_cnt8", 64'(bus.rob_count), 8);

    // clean slate, then exception flush
    reset = 0;
    tick();
    reset = 1;
    tick();
    bus.alloc_valid = 1;
    tick(); tick(); tick(); tick();
    bus.alloc_valid = 0;
    done(0, 1);
    bus.exception = 1;
    bus.virtual_addr_exception = 12;
    bus.pc = 4;
    tick();
    idle();
    done(2, 77);
    settle();
    chk("exc_cv", 64'(bus.commit_valid), 1);
    chk("exc_flag", 64'(bus.commit_exception), 1);
    chk("exc_va", 64'(bus.commit_virtual_addr_exception), 12);
    chk("exc_pc", 64'(bus.commit_pc), 4);
    tick();
    settle();
    chk("fl_flush", 64'(bus.flush), 1);
    chk("fl_cnt", 64'(bus.rob_count), 0);
    chk("fl_rdy", 64'(bus.alloc_ready), 0);
    chk("fl_cv", 64'(bus.commit_valid), 0);
    tick();
    idle();
    settle();
    chk("fl_off", 64'(bus.flush), 0);
    chk("fl_cv2", 64'(bus.commit_valid), 0);
    chk("fl_id", 64'(bus.alloc_rob_id), 0);
    chk("fl_rdy2", 64'(bus.alloc_ready), 1);

    // head completion latency
    bus.alloc_valid = 1;
    tick();
    bus.alloc_valid = 0;
    done(0, 42);
    settle();
`ifdef ROB_COMMIT_BYPASS_EN
    chk("byp_cv", 64'(bus.commit_valid), 1);
    chk("byp_res", 64'(bus.commit_aluResult), 42);
    tick();
    idle();
    settle();
    chk("byp_after", 64'(bus.commit_valid), 0);
    chk("byp_cnt", 64'(bus.rob_count), 0);
`else
    chk("nb_cv", 64'(bus.commit_valid), 0);
    tick();
    idle();
    settle();
    chk("nb_cv2", 64'(bus.commit_valid), 1);
    chk("nb_res", 64'(bus.commit_aluResult), 42);
    tick();
    chk("nb_cnt", 64'(bus.rob_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
